// File: rtl/snake_rules.sv
// snake_rules: game-rule engine for the VGA snake game.
// Produces the movement tick, places apples from an LFSR, keeps the score,
// latches game-over on a border hit or self-collision, and flags border pixels.
module snake_rules #(
    parameter int DIVIDER = 25_000_000,
    parameter int CELL    = 20,
    parameter int SEGS    = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           snakex,
    input  logic [9:0]           snakey,
    input  logic [10*SEGS-1:0]   storex,
    input  logic [10*SEGS-1:0]   storey,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    output logic                 tick,
    output logic [9:0]           applex,
    output logic [9:0]           appley,
    output logic [7:0]           score,
    output logic                 game_over,
    output logic                 border
);

    localparam int              CW        = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DIVIDER - 1);
    localparam logic [7:0]      SCORE_MAX = 8'(SEGS - 2);

    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [15:0]     lfsr_reg;
    logic [SEGS-1:0] seg_hit;
    logic            head_in_ring;
    logic            pix_in_ring;
    logic            collide;
    logic            eat;
    logic [4:0]      a_col;
    logic [4:0]      b_row;
    logic [9:0]      col_idx;
    logic [9:0]      row_idx;
    logic [9:0]      alt_idx;
    logic [9:0]      new_x;
    logic [9:0]      new_y;
    logic [9:0]      alt_x;
    logic [9:0]      place_x;

    // Border ring of the 640x480 play area; unsigned, so wrapped heads count too.
    function automatic logic in_ring(input logic [9:0] px, input logic [9:0] py);
        return (px < 10'd20) || (px >= 10'd620) || (py < 10'd20) || (py >= 10'd460);
    endfunction

    assign head_in_ring = in_ring(snakex, snakey);
    assign pix_in_ring  = in_ring(x, y);

    // Next value of the free-running tick counter.
    always_comb begin
        cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
    end

    // Tick counter; the pulse is registered so it coincides with count DIVIDER-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            tick    <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            tick    <= (cnt_next == CNT_LAST);
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11, free-running every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    // Candidate apple position: folds LFSR fields into 30 columns by 22 rows
    // inside the ring, shifting one column over if it would land on the head.
    always_comb begin
        a_col   = (lfsr_reg[4:0] >= 5'd30) ? lfsr_reg[4:0] - 5'd30 : lfsr_reg[4:0];
        b_row   = (lfsr_reg[9:5] >= 5'd22) ? lfsr_reg[9:5] - 5'd22 : lfsr_reg[9:5];
        col_idx = {5'd0, a_col} + 10'd1;
        row_idx = {5'd0, b_row} + 10'd1;
        alt_idx = (col_idx == 10'd30) ? 10'd1 : col_idx + 10'd1;
        new_x   = 10'(col_idx * CELL);
        new_y   = 10'(row_idx * CELL);
        alt_x   = 10'(alt_idx * CELL);
        place_x = ((new_x == snakex) && (new_y == snakey)) ? alt_x : new_x;
    end

    // Per-segment collision; segments beyond the first two only count once
    // the snake has grown far enough to reach them.
    genvar gi;
    generate
        for (gi = 0; gi < SEGS; gi++) begin : g_seg
            logic seg_active;
            if (gi < 2) begin : g_fixed
                assign seg_active = 1'b1;
            end else begin : g_grown
                assign seg_active = (score > 8'(gi - 2));
            end
            assign seg_hit[gi] = seg_active
                               && (snakex == storex[10*gi +: 10])
                               && (snakey == storey[10*gi +: 10]);
        end
    endgenerate

    assign collide = |seg_hit;
    assign eat     = (snakex == applex) && (snakey == appley) && !game_over;

    // Game state: sticky loss flag, score/apple on eat, registered border pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            score     <= 8'd0;
            applex    <= 10'd480;
            appley    <= 10'd280;
            game_over <= 1'b0;
            border    <= 1'b0;
        end else begin
            border <= pix_in_ring;
            if (head_in_ring || collide) begin
                game_over <= 1'b1;
            end
            if (eat) begin
                if (score < SCORE_MAX) begin
                    score <= score + 8'd1;
                end
                applex <= place_x;
                appley <= new_y;
            end
        end
    end

endmodule

// File: tb/tb_snake_rules.sv
// tb_snake_rules: scoreboard bench for snake_rules with a fast tick (DIVIDER=4).
module tb_snake_rules;

    localparam int SEGS = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic [9:0]         snakex, snakey, x, y;
    logic [10*SEGS-1:0] storex, storey;
    logic               tick, game_over, border;
    logic [9:0]         applex, appley;
    logic [7:0]         score;

    snake_rules #(.DIVIDER(4), .CELL(20), .SEGS(SEGS)) dut (
        .clk(clk), .rst(rst), .snakex(snakex), .snakey(snakey),
        .storex(storex), .storey(storey), .x(x), .y(y),
        .tick(tick), .applex(applex), .appley(appley), .score(score),
        .game_over(game_over), .border(border)
    );

    always #5 clk = ~clk;

    typedef enum int {O_SCORE, O_AX, O_AY, O_GO, O_BORDER, O_TICK} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_score;
    logic [9:0]  exp_ax, exp_ay;
    logic [15:0] lfsr_m;

    // Reference LFSR, follows the same reset and shift rule as the design.
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    function automatic logic [19:0] place(input logic [15:0] l, input logic [9:0] hx, input logic [9:0] hy);
        int a, b, nx, ny;
        a = int'(l[4:0]); if (a >= 30) a -= 30;
        b = int'(l[9:5]); if (b >= 22) b -= 22;
        nx = (a + 1) * 20;
        ny = (b + 1) * 20;
        if (nx == int'(hx) && ny == int'(hy)) nx = (((a + 1) % 30) + 1) * 20;
        return {10'(nx), 10'(ny)};
    endfunction

    function automatic logic [31:0] observe(input sel_t s);
        case (s)
            O_SCORE:  return {24'd0, score};
            O_AX:     return {22'd0, applex};
            O_AY:     return {22'd0, appley};
            O_GO:     return {31'd0, game_over};
            O_BORDER: return {31'd0, border};
            O_TICK:   return {31'd0, tick};
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input sel_t sel, input int exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = 32'(exp);
        sb_q.push_back(e);
    endtask

    // One clock; everything queued before the edge is compared just after it.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        snakex = 10'd300; snakey = 10'd300; x = 10'd300; y = 10'd300;
        storex = {SEGS{10'd700}}; storey = {SEGS{10'd700}};
        push_exp("rst_score", O_SCORE, 0);
        push_exp("rst_applex", O_AX, 480);
        push_exp("rst_appley", O_AY, 280);
        push_exp("rst_game_over", O_GO, 0);
        push_exp("rst_tick", O_TICK, 0);
        push_exp("rst_border", O_BORDER, 0);
        step();
        rst = 1'b0;
        exp_score = 0; exp_ax = 10'd480; exp_ay = 10'd280;
    endtask

    task automatic eat_once(input string tag, input int exp_go);
        logic [19:0] p;
        snakex = exp_ax; snakey = exp_ay;
        p = place(lfsr_m, exp_ax, exp_ay);
        if (exp_score < SEGS - 2) exp_score++;
        exp_ax = p[19:10]; exp_ay = p[9:0];
        push_exp({tag, "_score"}, O_SCORE, exp_score);
        push_exp({tag, "_applex"}, O_AX, int'(exp_ax));
        push_exp({tag, "_appley"}, O_AY, int'(exp_ay));
        push_exp({tag, "_game_over"}, O_GO, exp_go);
        step();
        $display("eat %s: head (%0d,%0d) -> score %0d apple (%0d,%0d)",
                 tag, snakex, snakey, score, applex, appley);
    endtask

    task automatic tick_run(input string tag);
        for (int k = 1; k <= 8; k++) begin
            push_exp(tag, O_TICK, (k % 4 == 3) ? 1 : 0);
            step();
        end
    endtask

    initial begin
        // Reset held for two clocks, then tick cadence and idle state.
        do_reset();
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            push_exp("tick_cadence", O_TICK, (k % 4 == 3) ? 1 : 0);
            push_exp("idle_game_over", O_GO, 0);
            step();
        end

        // Score 0: segment 2 is not yet part of the body.
        storex[20 +: 10] = 10'd300; storey[20 +: 10] = 10'd300;
        for (int k = 0; k < 3; k++) begin
            push_exp("seg2_inactive", O_GO, 0);
            step();
        end
        storex[20 +: 10] = 10'd700; storey[20 +: 10] = 10'd700;

        // First apple, then hold the head there: score must not climb again.
        eat_once("first", 0);
        check("apple_x_grid", 32'(applex % 20), 0);
        check("apple_y_grid", 32'(appley % 20), 0);
        check("apple_in_area", 32'(applex >= 20 && applex <= 600 && appley >= 20 && appley <= 440), 1);
        check("apple_moved", 32'(applex != 10'd480 || appley != 10'd280), 1);
        for (int k = 0; k < 9; k++) begin
            push_exp("hold_score", O_SCORE, 1);
            push_exp("hold_applex", O_AX, int'(exp_ax));
            step();
        end

        // Score 1: segment 2 now collides.
        storex[20 +: 10] = 10'd480; storey[20 +: 10] = 10'd280;
        push_exp("seg2_active", O_GO, 1);
        step();

        // Frozen after loss: head on apple changes nothing, tick keeps going.
        snakex = exp_ax; snakey = exp_ay;
        begin
            int tk = 0;
            for (int k = 0; k < 8; k++) begin
                push_exp("frozen_score", O_SCORE, 1);
                push_exp("frozen_applex", O_AX, int'(exp_ax));
                push_exp("frozen_appley", O_AY, int'(exp_ay));
                push_exp("frozen_game_over", O_GO, 1);
                step();
                tk += int'(tick);
            end
            check("tick_while_over", 32'(tk), 2);
        end

        // Segment 0 always collides.
        do_reset();
        storex[0 +: 10] = 10'd300; storey[0 +: 10] = 10'd300;
        push_exp("seg0_hit", O_GO, 1);
        step();

        // Border ring on the head, including a wrapped coordinate.
        do_reset();
        snakex = 10'd600; snakey = 10'd280;
        push_exp("head_600", O_GO, 0);
        step();
        snakex = 10'd620;
        push_exp("head_620", O_GO, 1);
        step();
        do_reset();
        snakex = 10'd1004; snakey = 10'd280;
        push_exp("head_wrapped", O_GO, 1);
        step();
        snakex = 10'd300; snakey = 10'd300;
        for (int k = 0; k < 3; k++) begin
            push_exp("sticky", O_GO, 1);
            step();
        end

        // Eat and collision on the same edge.
        do_reset();
        storex[0 +: 10] = 10'd480; storey[0 +: 10] = 10'd280;
        eat_once("eat_and_hit", 1);

        // Twenty eats saturate the score.
        do_reset();
        for (int k = 0; k < 20; k++) eat_once($sformatf("sat%0d", k), 0);
        check("score_saturated", {24'd0, score}, 32'(SEGS - 2));

        // Border pixel flag on the scan position.
        x = 10'd19;  y = 10'd100; push_exp("pix_19_100", O_BORDER, 1); step();
        x = 10'd20;  y = 10'd100; push_exp("pix_20_100", O_BORDER, 0); step();
        x = 10'd300; y = 10'd459; push_exp("pix_300_459", O_BORDER, 0); step();
        x = 10'd300; y = 10'd460; push_exp("pix_300_460", O_BORDER, 1); step();

        // Mid-game reset restarts a full tick period.
        do_reset();
        tick_run("tick_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
